// File: rtl/vga_mode_sequencer_if.sv
// Signal bundle between vga_mode_sequencer and the vga_sync / pattern side.
// master: the sequencer. slave: the environment (vga_sync, pin, pattern logic).
interface vga_mode_sequencer_if #(
  parameter int FRAME_CNT_W = 8
);
  logic                   i_mode_req;
  logic                   i_hmax;
  logic                   i_vmax;
  logic                   i_visible;
  logic                   o_mode;
  logic                   o_mute;
  logic                   o_visible_gated;
  logic                   o_frame_start;
  logic [FRAME_CNT_W-1:0] o_frame_count;
  logic                   o_busy;

  modport master (
    input  i_mode_req, i_hmax, i_vmax, i_visible,
    output o_mode, o_mute, o_visible_gated, o_frame_start, o_frame_count, o_busy
  );

  modport slave (
    output i_mode_req, i_hmax, i_vmax, i_visible,
    input  o_mode, o_mute, o_visible_gated, o_frame_start, o_frame_count, o_busy
  );
endinterface

// File: rtl/vga_mode_sequencer.sv
// Frame-aligned mode switcher for vga_sync: synchronises the mode pin,
// qualifies it over whole frames, commits on the frame-end edge and then
// blanks video for a fixed number of frames so the monitor can re-lock.
module vga_mode_sequencer #(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_FRAMES = 2,
  parameter int MUTE_FRAMES   = 3,
  parameter int FRAME_CNT_W   = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  vga_mode_sequencer_if.master  bus
);

  localparam int SC_W = (STABLE_FRAMES < 2) ? 1 : $clog2(STABLE_FRAMES + 1);

  typedef enum logic [1:0] {IDLE, QUALIFY, MUTE} state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_pipe;
  logic                   mode_q, mode_d;
  logic                   cand_q, cand_d;
  logic [SC_W-1:0]        stable_q, stable_d;
  logic [7:0]             mute_q, mute_d;
  logic                   frame_start_q;
  logic [FRAME_CNT_W-1:0] frame_cnt_q;

  logic req_s;
  logic frame_end;

  assign req_s     = sync_pipe[SYNC_STAGES-1];
  assign frame_end = bus.i_hmax & bus.i_vmax;

  // Synchroniser chain for the asynchronous request pin; runs in every state.
  always_ff @(posedge clk) begin
    if (reset) sync_pipe <= '0;
    else       sync_pipe <= {sync_pipe[SYNC_STAGES-2:0], bus.i_mode_req};
  end

  // Frame bookkeeping: completed-frame count and a strobe on the first pixel.
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_cnt_q   <= '0;
      frame_start_q <= 1'b0;
    end else begin
      frame_cnt_q   <= frame_cnt_q + FRAME_CNT_W'(frame_end);
      frame_start_q <= frame_end;
    end
  end

  // Next-state logic. The commit coincides with vga_sync wrapping to 0,0,
  // so the new mode always starts on a clean frame.
  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    cand_d   = cand_q;
    stable_d = stable_q;
    mute_d   = mute_q;
    case (state_q)
      IDLE: begin
        if (req_s != mode_q) begin
          state_d  = QUALIFY;
          cand_d   = req_s;
          stable_d = '0;
        end
      end
      QUALIFY: begin
        // A withdrawn request wins over a coincident frame end.
        if (req_s != cand_q) begin
          state_d = IDLE;
        end else if (frame_end) begin
          if (stable_q == SC_W'(STABLE_FRAMES - 1)) begin
            mode_d  = cand_q;
            mute_d  = 8'(MUTE_FRAMES);
            state_d = MUTE;
          end else begin
            stable_d = stable_q + SC_W'(1);
          end
        end
      end
      MUTE: begin
        if (frame_end) begin
          if (mute_q == 8'd1) state_d = IDLE;
          else                mute_d  = mute_q - 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; reset restarts the mute period in mode 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= MUTE;
      mode_q   <= 1'b0;
      cand_q   <= 1'b0;
      stable_q <= '0;
      mute_q   <= 8'(MUTE_FRAMES);
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      cand_q   <= cand_d;
      stable_q <= stable_d;
      mute_q   <= mute_d;
    end
  end

  assign bus.o_mode          = mode_q;
  assign bus.o_mute          = (state_q == MUTE);
  assign bus.o_busy          = (state_q != IDLE);
  assign bus.o_visible_gated = bus.i_visible & ~bus.o_mute;
  assign bus.o_frame_start   = frame_start_q;
  assign bus.o_frame_count   = frame_cnt_q;

endmodule

// File: tb/tb_vga_mode_sequencer.sv
// Bench for vga_mode_sequencer: a small mode-dependent raster generator
// stands in for vga_sync, and a frame-level reference model predicts outputs.
module tb_vga_mode_sequencer;

  localparam int SYNC_STAGES   = 2;
  localparam int STABLE_FRAMES = 2;
  localparam int MUTE_FRAMES   = 3;
  localparam int FRAME_CNT_W   = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  vga_mode_sequencer_if #(.FRAME_CNT_W(FRAME_CNT_W)) bus ();

  vga_mode_sequencer #(
    .SYNC_STAGES(SYNC_STAGES), .STABLE_FRAMES(STABLE_FRAMES),
    .MUTE_FRAMES(MUTE_FRAMES), .FRAME_CNT_W(FRAME_CNT_W)
  ) dut (.clk(clk), .reset(reset), .bus(bus));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Raster stand-in: mode 0 is 10x6 pixels, mode 1 is 8x5.
  int hpos = 0, vpos = 0;
  int hlen, vlen;
  assign hlen = bus.o_mode ? 8 : 10;
  assign vlen = bus.o_mode ? 5 : 6;
  assign bus.i_hmax    = (hpos == hlen - 1);
  assign bus.i_vmax    = (vpos == vlen - 1);
  assign bus.i_visible = (hpos < hlen - 2) && (vpos < vlen - 1);

  always @(posedge clk) begin
    if (reset) begin
      hpos <= 0; vpos <= 0;
    end else if (hpos >= hlen - 1) begin
      hpos <= 0;
      vpos <= (vpos >= vlen - 1) ? 0 : vpos + 1;
    end else begin
      hpos <= hpos + 1;
    end
  end

  // Reference model: frame-level bookkeeping of pending request, frames seen
  // stable, and frames of mute left.
  logic mode_req = 1'b0;
  assign bus.i_mode_req = mode_req;

  bit m_hist[SYNC_STAGES];
  bit m_mode, m_cand, m_pend, m_fs;
  int m_qual, m_mute_left, m_cnt;
  int fe_seen = 0;

  always @(posedge clk) begin
    bit fe, rq;
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) m_hist[i] = 1'b0;
      m_mode = 0; m_cand = 0; m_pend = 0; m_fs = 0;
      m_qual = 0; m_cnt = 0; m_mute_left = MUTE_FRAMES;
    end else begin
      fe = bus.i_hmax & bus.i_vmax;
      rq = m_hist[SYNC_STAGES-1];
      m_fs = fe;
      if (fe) begin
        m_cnt = (m_cnt + 1) % (1 << FRAME_CNT_W);
        fe_seen++;
      end
      if (m_mute_left > 0) begin
        if (fe) m_mute_left--;
      end else if (m_pend) begin
        if (rq != m_cand) m_pend = 0;
        else if (fe) begin
          m_qual++;
          if (m_qual == STABLE_FRAMES) begin
            m_mode = m_cand; m_pend = 0; m_mute_left = MUTE_FRAMES;
          end
        end
      end else if (rq != m_mode) begin
        m_pend = 1; m_cand = rq; m_qual = 0;
      end
      for (int i = SYNC_STAGES - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
      m_hist[0] = mode_req;
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  bit chk_en = 0;
  logic prev_mode = 1'b0;
  always @(negedge clk) begin
    if (chk_en) begin
      chk("mode",  bus.o_mode, m_mode);
      chk("mute",  bus.o_mute, m_mute_left > 0);
      chk("busy",  bus.o_busy, (m_mute_left > 0) || m_pend);
      chk("fstart", bus.o_frame_start, m_fs);
      chk("fcount", bus.o_frame_count, m_cnt);
      chk("vis_gated", bus.o_visible_gated, bus.i_visible & (m_mute_left == 0));
      if (bus.o_mode !== prev_mode)
        chk("midframe", (hpos == 0) && (vpos == 0), 1);
      prev_mode = bus.o_mode;
    end
  end

  task automatic step();
    @(posedge clk); #2;
  endtask

  task automatic wait_fe(input int n);
    int target, cyc;
    target = fe_seen + n;
    cyc = 0;
    while (fe_seen < target && cyc < 200 * n) begin
      step();
      cyc++;
    end
    if (fe_seen < target) chk("fe_timeout", 0, 1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; mode_req = 1'b0;
    step(); chk_en = 1;
    step(); step();
    chk("rst_mode", bus.o_mode, 0);
    chk("rst_mute", bus.o_mute, 1);
    chk("rst_busy", bus.o_busy, 1);
    chk("rst_count", bus.o_frame_count, 0);
    reset = 1'b0;

    // Power-up mute spans three frames.
    wait_fe(2);
    chk("mute_f2", bus.o_mute, 1);
    wait_fe(1);
    chk("mute_f3", bus.o_mute, 0);
    chk("busy_f3", bus.o_busy, 0);
    wait_fe(2);
    chk("count5", bus.o_frame_count, 5);
    chk("mode0", bus.o_mode, 0);

    // Mid-frame request: busy after sync + 1 cycles, commit on 2nd frame end.
    repeat (5) step();
    mode_req = 1'b1;
    step(); step();
    chk("busy_early", bus.o_busy, 0);
    step();
    chk("busy_rise", bus.o_busy, 1);
    wait_fe(1);
    chk("no_commit1", bus.o_mode, 0);
    wait_fe(1);
    chk("commit_mode", bus.o_mode, 1);
    chk("commit_mute", bus.o_mute, 1);
    wait_fe(3);
    chk("mute_clear", bus.o_mute, 0);

    // Withdrawn request: no commit, fresh qualification afterwards.
    repeat (5) step();
    mode_req = 1'b0;
    wait_fe(1);
    mode_req = 1'b1;
    repeat (10) step();
    chk("wd_busy", bus.o_busy, 0);
    chk("wd_mode", bus.o_mode, 1);
    chk("wd_mute", bus.o_mute, 0);
    mode_req = 1'b0;
    wait_fe(1);
    chk("fresh1", bus.o_mode, 1);
    wait_fe(1);
    chk("fresh2", bus.o_mode, 0);

    // Request during mute is held off until IDLE.
    mode_req = 1'b1;
    wait_fe(3);
    chk("mute_ign_mode", bus.o_mode, 0);
    chk("idle_busy", bus.o_busy, 0);
    step();
    chk("requal_busy", bus.o_busy, 1);
    wait_fe(2);
    chk("requal_mode", bus.o_mode, 1);

    // Reset during mute with mode 1.
    wait_fe(1);
    mode_req = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("mrst_mode", bus.o_mode, 0);
    chk("mrst_count", bus.o_frame_count, 0);
    chk("mrst_mute", bus.o_mute, 1);
    wait_fe(2);
    chk("mrst_mute2", bus.o_mute, 1);
    wait_fe(1);
    chk("mrst_mute3", bus.o_mute, 0);

    // Randomised traffic, model checks every cycle.
    for (int it = 0; it < 200; it++) begin
      mode_req = 1'($urandom % 2);
      if ($urandom % 30 == 0) begin
        reset = 1'b1;
        repeat ($urandom_range(1, 2)) step();
        reset = 1'b0;
      end
      repeat ($urandom_range(1, 120)) step();
    end

    // Counter wrap after 256 frames.
    mode_req = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    wait_fe(255);
    chk("count255", bus.o_frame_count, 255);
    wait_fe(1);
    chk("count_wrap", bus.o_frame_count, 0);
    repeat (3) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
